// File: rtl/pwm_modulator.sv
// PWM modulator: free-running period counter with optional prescaler and a
// duty shadow register that only reloads on the period wrap.
module pwm_modulator #(
    parameter int unsigned N       = 8,
    parameter int unsigned CLK_DIV = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] duty,
    output logic         out,
    output logic         period_done
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [N-1:0]  CNT_MAX = '1;

    logic [PW-1:0] pre_q, pre_d;
    logic [N-1:0]  cnt_q, cnt_d;
    logic [N-1:0]  duty_q, duty_d;
    logic          period_done_q, period_done_d;
    logic          tick_c;

    // Next-state: prescaler advances on ena, period counter on tick, shadow duty on wrap.
    always_comb begin
        pre_d         = pre_q;
        cnt_d         = cnt_q;
        duty_d        = duty_q;
        period_done_d = 1'b0;
        tick_c        = ena && (pre_q == PRE_MAX);

        if (ena) begin
            pre_d = tick_c ? '0 : pre_q + PW'(1);
        end

        if (tick_c) begin
            cnt_d = cnt_q + N'(1);
            if (cnt_q == CNT_MAX) begin
                duty_d        = duty;
                period_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q         <= '0;
            cnt_q         <= '0;
            duty_q        <= '0;
            period_done_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            cnt_q         <= cnt_d;
            duty_q        <= duty_d;
            period_done_q <= period_done_d;
        end
    end

    // Output decoded purely from registers, so duty/ena never reach it combinationally.
    assign out         = (cnt_q < duty_q);
    assign period_done = period_done_q;

endmodule

// File: tb/tb_pwm_modulator.sv
// Directed bench for pwm_modulator: N=8 core behaviour, N=4 prescaled,
// and N=4 closed loop with a behavioural triangle generator.
module tb_pwm_modulator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       ena8 = 1'b0;
    logic [7:0] duty8 = '0;
    logic       out8, pd8;

    logic       ena4p = 1'b0;
    logic [3:0] duty4p = '0;
    logic       out4p, pd4p;

    logic       ena4l = 1'b0;
    logic [3:0] tri_lvl;
    logic       dir_up;
    logic       out4l, pd4l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_modulator #(.N(8), .CLK_DIV(1)) u8 (
        .clk(clk), .rst(rst), .ena(ena8), .duty(duty8),
        .out(out8), .period_done(pd8)
    );

    pwm_modulator #(.N(4), .CLK_DIV(4)) u4p (
        .clk(clk), .rst(rst), .ena(ena4p), .duty(duty4p),
        .out(out4p), .period_done(pd4p)
    );

    pwm_modulator #(.N(4), .CLK_DIV(1)) u4l (
        .clk(clk), .rst(rst), .ena(ena4l), .duty(tri_lvl),
        .out(out4l), .period_done(pd4l)
    );

    // Behavioural triangle generator 0..15..0, advanced by period_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tri_lvl <= '0;
            dir_up  <= 1'b1;
        end else if (pd4l) begin
            if (dir_up) begin
                if (tri_lvl == 4'd15) begin
                    dir_up  <= 1'b0;
                    tri_lvl <= 4'd14;
                end else begin
                    tri_lvl <= tri_lvl + 4'd1;
                end
            end else begin
                if (tri_lvl == 4'd0) begin
                    dir_up  <= 1'b1;
                    tri_lvl <= 4'd1;
                end else begin
                    tri_lvl <= tri_lvl - 4'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_out(input int id);
        case (id)
            0:       return out8;
            1:       return out4p;
            default: return out4l;
        endcase
    endfunction

    function automatic logic get_pd(input int id);
        case (id)
            0:       return pd8;
            1:       return pd4p;
            default: return pd4l;
        endcase
    endfunction

    task automatic set_duty(input int id, input logic [7:0] v);
        case (id)
            0:       duty8  = v;
            1:       duty4p = 4'(v);
            default: ;
        endcase
    endtask

    task automatic set_ena(input int id, input logic v);
        case (id)
            0:       ena8  = v;
            1:       ena4p = v;
            default: ena4l = v;
        endcase
    endtask

    // Raise reset between clock edges and confirm outputs clear before any edge.
    task automatic do_reset(input int id);
        #2;
        rst = 1'b1;
        #1;
        check("rst_out", int'(get_out(id)), 0);
        check("rst_pd", int'(get_pd(id)), 0);
        step();
    endtask

    // Count cycles (and high samples) from reset release to the first strobe.
    task automatic wait_pd(input int id, output int cycles, output int hi);
        cycles = 0;
        hi     = 0;
        while (1) begin
            step();
            cycles++;
            if (get_pd(id)) break;
            if (get_out(id)) hi++;
            if (cycles > 5000) begin
                check("wait_pd_timeout", cycles, 0);
                break;
            end
        end
    endtask

    // Measure one period starting at a strobe sample; optional duty change and ena gap.
    task automatic run_period(input int id, input int chg_at, input logic [7:0] chg_val,
                              input int gate_at, input int gate_len,
                              output int hi, output int len, output int first_low,
                              output int last_out, output int wall);
        logic o;
        hi = 0; len = 0; first_low = 0; last_out = 0; wall = 0;
        while (1) begin
            o = get_out(id);
            len++;
            wall++;
            if (o) hi++;
            else if (first_low == 0) first_low = len;
            last_out = int'(o);
            if (len == chg_at) set_duty(id, chg_val);
            if (len == gate_at) begin
                set_ena(id, 1'b0);
                for (int g = 0; g < gate_len; g++) begin
                    step();
                    wall++;
                    check("gate_pd", int'(get_pd(id)), 0);
                    check("gate_out", int'(get_out(id)), int'(o));
                end
                set_ena(id, 1'b1);
            end
            step();
            if (get_pd(id)) break;
            if (len > 5000) begin
                check("period_timeout", len, 0);
                break;
            end
        end
    endtask

    initial begin
        int cyc, hi, len, fl, lo, wall;
        string s;

        // ---- N=8, CLK_DIV=1: reset, first all-low period, duty 64 ----
        do_reset(0);
        duty8 = 8'd64; ena8 = 1'b1; rst = 1'b0;
        wait_pd(0, cyc, hi);
        check("first_pd_cycle", cyc, 256);
        check("first_period_hi", hi, 0);
        for (int p = 0; p < 2; p++) begin
            run_period(0, 0, 8'd0, 0, 0, hi, len, fl, lo, wall);
            check("d64_hi", hi, 64);
            check("d64_len", len, 256);
            check("d64_first_low", fl, 65);
        end

        // Reset mid high phase must clear output without a clock edge.
        for (int k = 0; k < 5; k++) step();
        check("pre_rst_out", int'(out8), 1);
        do_reset(0);

        // ---- duty 0 for 3 periods, then 255 ----
        duty8 = 8'd0; rst = 1'b0;
        wait_pd(0, cyc, hi);
        check("d0_first_pd", cyc, 256);
        for (int p = 0; p < 3; p++) begin
            run_period(0, (p == 2) ? 1 : 0, 8'd255, 0, 0, hi, len, fl, lo, wall);
            check("d0_hi", hi, 0);
            check("d0_len", len, 256);
        end
        run_period(0, 1, 8'd64, 0, 0, hi, len, fl, lo, wall);
        check("d255_hi", hi, 255);
        check("d255_first_low", fl, 256);
        check("d255_last_low", lo, 0);
        check("d255_len", len, 256);

        // ---- double buffering: change 64 -> 200 at cnt=10 ----
        run_period(0, 11, 8'd200, 0, 0, hi, len, fl, lo, wall);
        check("dbuf_cur_hi", hi, 64);
        run_period(0, 0, 8'd0, 0, 0, hi, len, fl, lo, wall);
        check("dbuf_next_hi", hi, 200);
        check("dbuf_next_first_low", fl, 201);

        // ---- enable gap of 17 cycles at cnt=30 ----
        run_period(0, 0, 8'd0, 31, 17, hi, len, fl, lo, wall);
        check("gate_hi", hi, 200);
        check("gate_len", len, 256);
        check("gate_wall", wall, 273);
        ena8 = 1'b0;

        // ---- N=4, CLK_DIV=4, duty 5 ----
        do_reset(1);
        duty4p = 4'd5; ena4p = 1'b1; rst = 1'b0;
        wait_pd(1, cyc, hi);
        check("pre_first_pd", cyc, 64);
        check("pre_first_hi", hi, 0);
        for (int p = 0; p < 2; p++) begin
            run_period(1, 0, 8'd0, 0, 0, hi, len, fl, lo, wall);
            check("pre_hi", hi, 20);
            check("pre_len", len, 64);
            check("pre_first_low", fl, 21);
        end
        ena4p = 1'b0;

        // ---- N=4 loop with triangle generator ----
        do_reset(2);
        ena4l = 1'b1; rst = 1'b0;
        wait_pd(2, cyc, hi);
        check("loop_first_pd", cyc, 16);
        for (int k = 0; k <= 30; k++) begin
            run_period(2, 0, 8'd0, 0, 0, hi, len, fl, lo, wall);
            s = $sformatf("loop_hi_%0d", k);
            check(s, hi, (k <= 15) ? k : 30 - k);
            check("loop_len", len, 16);
        end
        ena4l = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
